// File: rtl/note_pkg.sv
// Shared constants, FSM encoding and lane geometry for the note lane engine.
package note_pkg;

  localparam int VIDEO_WIDTH  = 640;
  localparam int VIDEO_HEIGHT = 480;
  localparam int NOTE_W       = 50;
  localparam int SLOTS        = 8;

  // Left edge of each lane, lane 0 in the low 10 bits.
  localparam logic [39:0] LANE_X = {10'd470, 10'd370, 10'd270, 10'd170};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SPAWN = 3'd3,
    ST_MOVE  = 3'd4
  } state_e;

  // Left edge x coordinate of a lane.
  function automatic logic [9:0] lane_x(input logic [1:0] lane);
    logic [9:0] x;
    case (lane)
      2'd0:    x = LANE_X[9:0];
      2'd1:    x = LANE_X[19:10];
      2'd2:    x = LANE_X[29:20];
      2'd3:    x = LANE_X[39:30];
      default: x = LANE_X[9:0];
    endcase
    return x;
  endfunction

endpackage

// File: rtl/note_rect_hit.sv
// Combinational point-in-square test for one note slot.
module note_rect_hit #(
  parameter int NOTE_W = 50
) (
  input  logic [9:0]        lane_x,
  input  logic signed [10:0] y,
  input  logic [9:0]        px,
  input  logic [8:0]        py,
  output logic              hit
);
  import note_pkg::*;

  logic [10:0]        x_hi_s;
  logic signed [11:0] y_lo_s;
  logic signed [11:0] y_hi_s;
  logic signed [11:0] py_s;

  // One extra bit keeps y+NOTE_W and lane_x+NOTE_W free of wrap-around.
  assign x_hi_s = {1'b0, lane_x} + 11'(NOTE_W);
  assign y_lo_s = {y[10], y};
  assign y_hi_s = y_lo_s + $signed(12'(NOTE_W));
  assign py_s   = $signed({3'b000, py});

  assign hit = (px >= lane_x) && ({1'b0, px} < x_hi_s) &&
               (py_s >= y_lo_s) && (py_s < y_hi_s);

endmodule

// File: rtl/note_lane_engine.sv
// Note lane engine: fetches chart rows, spawns falling notes into a slot
// pool, moves them once per frame and reports per-lane pixel hits.
module note_lane_engine #(
  parameter int SLOTS     = 8,
  parameter int CHART_LEN = 64,
  parameter int SPEED     = 2,
  parameter int NOTE_W    = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       spawn_tick,
  output logic [5:0] chart_addr,
  input  logic [3:0] chart_data,
  input  logic [9:0] px,
  input  logic [8:0] py,
  output logic [3:0] lane_hit,
  output logic [3:0] active_count,
  output logic [7:0] drop_count,
  output logic       chart_done,
  output logic       busy
);
  import note_pkg::*;

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic signed [10:0] SPAWN_Y  = 11'(-NOTE_W);
  localparam logic signed [10:0] RETIRE_Y = 11'(VIDEO_HEIGHT);
  localparam logic signed [10:0] STEP     = 11'(SPEED);
  localparam logic [5:0]         LAST_ROW = 6'(CHART_LEN - 1);
  localparam logic [IW-1:0]      LAST_SLOT = IW'(SLOTS - 1);

  state_e             state_q, state_d;
  logic               spawn_pend_q, spawn_pend_d;
  logic               frame_pend_q, frame_pend_d;
  logic [3:0]         mask_q, mask_d;
  logic [5:0]         addr_q, addr_d;
  logic               done_q, done_d;
  logic [7:0]         drop_q, drop_d;
  logic [1:0]         lane_sel_q, lane_sel_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [SLOTS-1:0]   valid_q, valid_d;
  logic [1:0]         slot_lane_q [SLOTS];
  logic [1:0]         slot_lane_d [SLOTS];
  logic signed [10:0] slot_y_q [SLOTS];
  logic signed [10:0] slot_y_d [SLOTS];
  logic [3:0]         count_q, count_d;
  logic [3:0]         hit_q, hit_d;
  logic [SLOTS-1:0]   rect_hit_s;
  logic               free_found_s;
  logic [IW-1:0]      free_idx_s;
  logic signed [10:0] y_next_s;

  assign y_next_s = slot_y_q[idx_q] + STEP;

  // Lowest-index free slot (descending scan so the lowest index wins).
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      free_idx_s   = valid_q[s] ? free_idx_s : IW'(s);
      free_found_s = free_found_s | ~valid_q[s];
    end
  end

  // Next-state, request bookkeeping and slot updates.
  always_comb begin
    state_d      = state_q;
    spawn_pend_d = spawn_pend_q | spawn_tick;
    frame_pend_d = frame_pend_q | frame_tick;
    mask_d       = mask_q;
    addr_d       = addr_q;
    done_d       = done_q;
    drop_d       = drop_q;
    lane_sel_d   = lane_sel_q;
    idx_d        = idx_q;
    valid_d      = valid_q;
    slot_lane_d  = slot_lane_q;
    slot_y_d     = slot_y_q;
    count_d      = 4'd0;
    case (state_q)
      ST_IDLE: begin
        if (spawn_pend_q && !done_q) begin
          state_d      = ST_FETCH;
          spawn_pend_d = spawn_tick;
        end else begin
          // Chart exhausted: a pending spawn is simply discarded.
          spawn_pend_d = spawn_tick;
          if (frame_pend_q) begin
            state_d      = ST_MOVE;
            frame_pend_d = frame_tick;
            idx_d        = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FETCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        mask_d     = chart_data;
        lane_sel_d = 2'd0;
        state_d    = ST_SPAWN;
        if (addr_q == LAST_ROW) begin
          done_d = 1'b1;
        end else begin
          addr_d = addr_q + 6'd1;
        end
      end
      ST_SPAWN: begin
        if (mask_q[lane_sel_q]) begin
          if (free_found_s) begin
            valid_d[free_idx_s]     = 1'b1;
            slot_lane_d[free_idx_s] = lane_sel_q;
            slot_y_d[free_idx_s]    = SPAWN_Y;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end else begin
            drop_d = drop_q;
          end
        end else begin
          drop_d = drop_q;
        end
        if (lane_sel_q == 2'd3) begin
          state_d = ST_IDLE;
        end else begin
          lane_sel_d = lane_sel_q + 2'd1;
        end
      end
      ST_MOVE: begin
        if (valid_q[idx_q]) begin
          slot_y_d[idx_q] = y_next_s;
          if (y_next_s >= RETIRE_Y) begin
            valid_d[idx_q] = 1'b0;
          end else begin
            valid_d[idx_q] = 1'b1;
          end
        end else begin
          valid_d[idx_q] = 1'b0;
        end
        if (idx_q == LAST_SLOT) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    for (int s = 0; s < SLOTS; s++) begin
      count_d = count_d + {3'b000, valid_d[s]};
    end
  end

  // Per-slot rectangle testers.
  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    logic [9:0] lane_x_s;
    assign lane_x_s = lane_x(slot_lane_q[s]);
    note_rect_hit #(.NOTE_W(NOTE_W)) u_rect (
      .lane_x (lane_x_s),
      .y      (slot_y_q[s]),
      .px     (px),
      .py     (py),
      .hit    (rect_hit_s[s])
    );
  end

  // OR the valid slot hits into their lanes.
  always_comb begin
    hit_d = 4'b0000;
    for (int s = 0; s < SLOTS; s++) begin
      hit_d[slot_lane_q[s]] = hit_d[slot_lane_q[s]] | (valid_q[s] & rect_hit_s[s]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, slot pool and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spawn_pend_q <= 1'b0;
      frame_pend_q <= 1'b0;
      mask_q       <= 4'd0;
      addr_q       <= 6'd0;
      done_q       <= 1'b0;
      drop_q       <= 8'd0;
      lane_sel_q   <= 2'd0;
      idx_q        <= '0;
      valid_q      <= '0;
      count_q      <= 4'd0;
      hit_q        <= 4'd0;
      for (int s = 0; s < SLOTS; s++) begin
        slot_lane_q[s] <= 2'd0;
        slot_y_q[s]    <= 11'sd0;
      end
    end else begin
      spawn_pend_q <= spawn_pend_d;
      frame_pend_q <= frame_pend_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      done_q       <= done_d;
      drop_q       <= drop_d;
      lane_sel_q   <= lane_sel_d;
      idx_q        <= idx_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      hit_q        <= hit_d;
      slot_lane_q  <= slot_lane_d;
      slot_y_q     <= slot_y_d;
    end
  end

  assign chart_addr   = addr_q;
  assign lane_hit     = hit_q;
  assign active_count = count_q;
  assign drop_count   = drop_q;
  assign chart_done   = done_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_note_lane_engine.sv
// Self-checking bench for note_lane_engine against a transaction-level model.
module tb_note_lane_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       spawn_tick;
  logic [5:0] chart_addr;
  logic [3:0] chart_data = 4'd0;
  logic [9:0] px;
  logic [8:0] py;
  logic [3:0] lane_hit;
  logic [3:0] active_count;
  logic [7:0] drop_count;
  logic       chart_done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [3:0] rom [64];
  int         lx [4] = '{170, 270, 370, 470};

  // Model: a set of notes, each with valid/lane/y, plus chart position.
  bit m_valid [8];
  int m_lane [8];
  int m_y [8];
  int m_drop;
  int m_row;
  bit m_done;

  always #5 clk = ~clk;

  // Synchronous chart ROM: data valid one cycle after the address.
  always @(posedge clk) chart_data <= rom[chart_addr];

  note_lane_engine dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .spawn_tick   (spawn_tick),
    .chart_addr   (chart_addr),
    .chart_data   (chart_data),
    .px           (px),
    .py           (py),
    .lane_hit     (lane_hit),
    .active_count (active_count),
    .drop_count   (drop_count),
    .chart_done   (chart_done),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_valid[s] = 1'b0;
      m_lane[s]  = 0;
      m_y[s]     = 0;
    end
    m_drop = 0;
    m_row  = 0;
    m_done = 1'b0;
  endtask

  task automatic model_spawn();
    logic [3:0] mask;
    bit placed;
    if (!m_done) begin
      mask = rom[m_row];
      for (int l = 0; l < 4; l++) begin
        if (mask[l]) begin
          placed = 1'b0;
          for (int s = 0; s < 8; s++) begin
            if (!placed && !m_valid[s]) begin
              m_valid[s] = 1'b1;
              m_lane[s]  = l;
              m_y[s]     = -50;
              placed     = 1'b1;
            end
          end
          if (!placed && m_drop < 255) m_drop++;
        end
      end
      if (m_row == 63) m_done = 1'b1;
      else m_row++;
    end
  endtask

  task automatic model_move();
    for (int s = 0; s < 8; s++) begin
      if (m_valid[s]) begin
        m_y[s] += 2;
        if (m_y[s] >= 480) m_valid[s] = 1'b0;
      end
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int s = 0; s < 8; s++) n += int'(m_valid[s]);
    return n;
  endfunction

  function automatic logic [3:0] model_hit(input int x, input int y);
    logic [3:0] h = 4'b0000;
    for (int s = 0; s < 8; s++) begin
      if (m_valid[s] && x >= lx[m_lane[s]] && x < lx[m_lane[s]] + 50 &&
          y >= m_y[s] && y < m_y[s] + 50)
        h[m_lane[s]] = 1'b1;
    end
    return h;
  endfunction

  task automatic compare_state(input string tag);
    check({tag, ".active_count"}, 32'(active_count), 32'(model_count()));
    check({tag, ".drop_count"}, 32'(drop_count), 32'(m_drop));
    check({tag, ".chart_done"}, 32'(chart_done), 32'(m_done));
    check({tag, ".chart_addr"}, 32'(chart_addr), 32'(m_row));
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic probe(input int x, input int y);
    px = 10'(x);
    py = 9'(y);
    cyc(1);
    check("lane_hit", 32'(lane_hit), 32'(model_hit(x, y)));
  endtask

  // Random points plus one point inside and one just right of each visible note.
  task automatic probe_all();
    int y0;
    int y1;
    int yy;
    probe($urandom_range(639, 0), $urandom_range(511, 0));
    probe($urandom_range(639, 0), $urandom_range(511, 0));
    for (int s = 0; s < 8; s++) begin
      if (m_valid[s]) begin
        y0 = (m_y[s] < 0) ? 0 : m_y[s];
        y1 = m_y[s] + 49;
        if (y1 >= 0 && y0 <= 511) begin
          yy = $urandom_range((y1 > 511) ? 511 : y1, y0);
          probe(lx[m_lane[s]] + $urandom_range(49, 0), yy);
          probe(lx[m_lane[s]] + 50, yy);
        end
      end
    end
  endtask

  task automatic pulse(input bit sp, input bit fr);
    spawn_tick = sp;
    frame_tick = fr;
    cyc(1);
    spawn_tick = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic serve(input bit sp, input bit fr, input int settle);
    pulse(sp, fr);
    cyc(settle);
    if (sp) model_spawn();
    if (fr) model_move();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(2);
    model_reset();
    check("rst.lane_hit", 32'(lane_hit), 32'd0);
    check("rst.active_count", 32'(active_count), 32'd0);
    check("rst.drop_count", 32'(drop_count), 32'd0);
    check("rst.chart_done", 32'(chart_done), 32'd0);
    check("rst.chart_addr", 32'(chart_addr), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    reset = 1'b1;
    cyc(1);
  endtask

  initial begin
    reset      = 1'b0;
    spawn_tick = 1'b0;
    frame_tick = 1'b0;
    px         = 10'd0;
    py         = 9'd0;
    for (int r = 0; r < 64; r++) rom[r] = 4'd0;

    // Basic spawn of two lanes, then partial visibility and joint requests.
    rom[0] = 4'b0101;
    rom[1] = 4'b1000;
    do_reset();
    pulse(1'b1, 1'b0);
    cyc(6);
    check("spawn6.active_count", 32'(active_count), 32'd2);
    cyc(14);
    model_spawn();
    compare_state("spawn1");
    probe(180, 0);
    check("hidden_note", 32'(lane_hit), 32'd0);
    serve(1'b0, 1'b1, 12);
    probe(175, 1);
    check("top_edge_lane0", 32'(lane_hit), 32'b0001);
    probe(375, 1);
    check("top_edge_lane2", 32'(lane_hit), 32'b0100);
    probe(175, 2);
    check("top_edge_below", 32'(lane_hit), 32'd0);
    serve(1'b1, 1'b1, 20);
    compare_state("both");
    probe(475, 0);
    check("both.lane3_y", 32'(lane_hit), 32'b1000);
    probe_all();

    // Fall all the way down to retirement.
    rom[0] = 4'b0011;
    do_reset();
    serve(1'b1, 1'b0, 20);
    compare_state("fall.spawn");
    for (int k = 1; k <= 265; k++) begin
      serve(1'b0, 1'b1, 12);
      if (k == 75) begin
        probe(300, 120);
        check("lane1_y100.in", 32'(lane_hit), 32'b0010);
        probe(320, 120);
        check("lane1_y100.out", 32'(lane_hit), 32'd0);
      end
      if (k == 264) check("fall.before_retire", 32'(active_count), 32'd2);
      if (k % 16 == 0) probe_all();
    end
    check("fall.retired", 32'(active_count), 32'd0);
    compare_state("fall.end");

    // Pool exhaustion.
    for (int r = 0; r < 9; r++) rom[r] = 4'b0001;
    do_reset();
    for (int r = 0; r < 9; r++) begin
      serve(1'b1, 1'b0, 20);
      if (r == 7) check("full.drop_before", 32'(drop_count), 32'd0);
    end
    check("full.drop", 32'(drop_count), 32'd1);
    check("full.active", 32'(active_count), 32'd8);
    compare_state("full");

    // Reset in the middle of a MOVE sweep.
    pulse(1'b0, 1'b1);
    cyc(4);
    check("midmove.busy", 32'(busy), 32'd1);
    reset = 1'b0;
    cyc(1);
    model_reset();
    check("midmove.active_count", 32'(active_count), 32'd0);
    check("midmove.drop_count", 32'(drop_count), 32'd0);
    check("midmove.busy", 32'(busy), 32'd0);
    check("midmove.lane_hit", 32'(lane_hit), 32'd0);
    check("midmove.chart_addr", 32'(chart_addr), 32'd0);
    check("midmove.chart_done", 32'(chart_done), 32'd0);
    reset = 1'b1;
    cyc(1);
    probe(175, 0);

    // Random chart played to the end, with random frames mixed in.
    for (int r = 0; r < 64; r++) rom[r] = 4'($urandom);
    while (!m_done) begin
      serve(1'b1, 1'($urandom_range(1, 0)), 20);
      compare_state("rand");
      probe($urandom_range(639, 0), $urandom_range(511, 0));
    end
    check("end.chart_done", 32'(chart_done), 32'd1);
    check("end.chart_addr", 32'(chart_addr), 32'd63);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0);
      for (int c = 0; c < 5; c++) begin
        cyc(1);
        check("done.busy", 32'(busy), 32'd0);
      end
      model_spawn();
      compare_state("done");
    end
    probe_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
